// File: rtl/alu_result_fifo_if.sv
// Handshake and status bundle between the ALU result FIFO and its
// producer/consumer. The FIFO takes the slave view; whatever feeds it
// and drains it takes the master view.
interface alu_result_fifo_if #(
    parameter int AW = 2,
    parameter int CW = 8
) ();

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [3:0]    in_result;
    logic          in_overflow;
    logic          in_zero;

    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_op;
    logic [3:0]    out_result;
    logic          out_overflow;
    logic          out_zero;

    logic [AW:0]   level;
    logic          ovf_sticky;
    logic [CW-1:0] ovf_count;
    logic          clr_status;

    modport master (
        output in_valid, in_op, in_result, in_overflow, in_zero,
        output out_ready, clr_status,
        input  in_ready, out_valid, out_op, out_result, out_overflow, out_zero,
        input  level, ovf_sticky, ovf_count
    );

    modport slave (
        input  in_valid, in_op, in_result, in_overflow, in_zero,
        input  out_ready, clr_status,
        output in_ready, out_valid, out_op, out_result, out_overflow, out_zero,
        output level, ovf_sticky, ovf_count
    );

endinterface

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: buffers {op, result, overflow, zero} tuples from the
// combinational ALU and hands them to a possibly stalling consumer under
// valid/ready. Also keeps a sticky overflow flag and a saturating count of
// accepted overflow results.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_fifo_if.slave  bus
);

    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    // Tuple layout: [8:6] op, [5:2] result, [1] overflow, [0] zero
    logic [8:0]    mem [DEPTH];

    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW:0]   level_q, level_d;
    logic          sticky_q, sticky_d;
    logic [CW-1:0] count_q, count_d;

    logic          inReady;
    logic          outValid;
    logic          push;
    logic          pop;
    logic          ovfPush;
    logic [8:0]    head;

    // Handshake qualifiers come only from the registered level, so there is
    // no combinational path from in_valid or out_ready to either ready/valid.
    assign inReady  = (level_q != FULL_LEVEL);
    assign outValid = (level_q != '0);
    assign push     = bus.in_valid && inReady;
    assign pop      = outValid && bus.out_ready;
    assign ovfPush  = push && bus.in_overflow;
    assign head     = mem[rdPtr_q];

    // Next-state for pointers, occupancy and overflow status; a same-cycle
    // overflow push beats clr_status so no event is lost.
    always_comb begin
        rdPtr_d  = rdPtr_q;
        wrPtr_d  = wrPtr_q;
        level_d  = level_q;
        sticky_d = sticky_q;
        count_d  = count_q;

        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end

        if (bus.clr_status) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
        if (ovfPush) begin
            sticky_d = 1'b1;
            if (bus.clr_status) begin
                count_d = CW'(1);
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Control and status registers, cleared asynchronously so a reset in
    // the middle of traffic throws away every buffered entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q  <= '0;
            wrPtr_q  <= '0;
            level_q  <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rdPtr_q  <= rdPtr_d;
            wrPtr_q  <= wrPtr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    // Tuple storage; contents are don't-care until written, since out_* is
    // masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= {bus.in_op, bus.in_result, bus.in_overflow, bus.in_zero};
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.out_valid    = outValid;
    assign bus.out_op       = outValid ? head[8:6] : 3'b000;
    assign bus.out_result   = outValid ? head[5:2] : 4'b0000;
    assign bus.out_overflow = outValid ? head[1]   : 1'b0;
    assign bus.out_zero     = outValid ? head[0]   : 1'b0;
    assign bus.level        = level_q;
    assign bus.ovf_sticky   = sticky_q;
    assign bus.ovf_count    = count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed scenarios plus a random phase, all
// checked against a queue-based model of the FIFO and its overflow status.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk;
    logic rst;

    alu_result_fifo_if #(.AW(AW), .CW(CW)) bus ();

    alu_result_fifo #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model: contents in arrival order plus overflow status
    logic [8:0] modelQ[$];
    bit         modelSticky;
    int         modelCnt;

    // Count one comparison and report it if it does not hold
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare every visible output against the model
    task automatic checkState();
        int         n;
        logic [8:0] h;
        n = modelQ.size();
        h = (n > 0) ? modelQ[0] : 9'd0;
        checkOutput("level",       32'(bus.level),        32'(n));
        checkOutput("outValid",    32'(bus.out_valid),    32'(n != 0));
        checkOutput("inReady",     32'(bus.in_ready),     32'(n != DEPTH));
        checkOutput("outOp",       32'(bus.out_op),       32'(h[8:6]));
        checkOutput("outResult",   32'(bus.out_result),   32'(h[5:2]));
        checkOutput("outOverflow", 32'(bus.out_overflow), 32'(h[1]));
        checkOutput("outZero",     32'(bus.out_zero),     32'(h[0]));
        checkOutput("ovfSticky",   32'(bus.ovf_sticky),   32'(modelSticky));
        checkOutput("ovfCount",    32'(bus.ovf_count),    32'(modelCnt));
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model by
    // what the handshake rules say happens at the rising edge, then check.
    task automatic applyStimulus(input bit v, input logic [2:0] op,
                                 input logic [3:0] res, input bit ovf,
                                 input bit zr, input bit rdy, input bit clr);
        bit doPush;
        bit doPop;
        bus.in_valid    = v;
        bus.in_op       = op;
        bus.in_result   = res;
        bus.in_overflow = ovf;
        bus.in_zero     = zr;
        bus.out_ready   = rdy;
        bus.clr_status  = clr;
        doPush = v && (modelQ.size() < DEPTH);
        doPop  = rdy && (modelQ.size() > 0);
        @(posedge clk);
        if (doPop) begin
            void'(modelQ.pop_front());
        end
        if (doPush) begin
            modelQ.push_back({op, res, ovf, zr});
        end
        modelSticky = (doPush && ovf) || (modelSticky && !clr);
        if (clr) begin
            modelCnt = (doPush && ovf) ? 1 : 0;
        end else if (doPush && ovf && modelCnt < CMAX) begin
            modelCnt = modelCnt + 1;
        end
        @(negedge clk);
        checkState();
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_op       = '0;
        bus.in_result   = '0;
        bus.in_overflow = 1'b0;
        bus.in_zero     = 1'b0;
        bus.out_ready   = 1'b0;
        bus.clr_status  = 1'b0;
        modelSticky = 1'b0;
        modelCnt    = 0;

        // Reset values while reset is held
        #3;
        checkState();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkState();

        // Single ADD entry, visible one cycle after push, then popped
        applyStimulus(1'b1, 3'b000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("firstResult", 32'(bus.out_result), 32'h5);
        checkOutput("firstLevel",  32'(bus.level),      32'd1);
        idle(1'b1);
        checkOutput("emptyResult", 32'(bus.out_result), 32'h0);

        // Fill to full, reject a fifth push, then drain in order
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 3'b000, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("fullInReady", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 3'b000, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rejectLevel", 32'(bus.level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drainOrder", 32'(bus.out_result), 32'(i));
            idle(1'b1);
        end

        // Full with push and pop both requested: only the pop happens
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'b010, 4'(i + 6), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 3'b011, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fullPopOnly", 32'(bus.level), 32'd3);
        applyStimulus(1'b1, 3'b011, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pushPopLevel", 32'(bus.level), 32'd3);
        repeat (3) idle(1'b1);

        // Overlapped streaming across pointer wrap
        applyStimulus(1'b1, 3'b100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 3'b100, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("streamLevel", 32'(bus.level), 32'd1);
        checkOutput("streamHead", 32'(bus.out_result), 32'd10);
        idle(1'b1);

        // Overflow status: three events, then clear colliding with a fourth
        applyStimulus(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'b001, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("ovfCount3", 32'(bus.ovf_count), 32'd3);
        applyStimulus(1'b1, 3'b001, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clrSetSticky", 32'(bus.ovf_sticky), 32'd1);
        checkOutput("clrIncCount",  32'(bus.ovf_count),  32'd1);

        // Saturation of the overflow counter
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 3'b001, 4'(i), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("ovfSaturate", 32'(bus.ovf_count), 32'd255);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom()),
                          4'($urandom()), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) == 0));
        end
        repeat (DEPTH) idle(1'b1);

        // Asynchronous reset with two overflow entries buffered
        applyStimulus(1'b1, 3'b001, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b001, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("preResetLevel", 32'(bus.level), 32'd2);
        #1 rst = 1'b1;
        #1;
        checkOutput("asyncLevel",    32'(bus.level),     32'd0);
        checkOutput("asyncOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("asyncOvfCount", 32'(bus.ovf_count), 32'd0);
        modelQ.delete();
        modelSticky = 1'b0;
        modelCnt    = 0;
        checkState();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        checkState();
        applyStimulus(1'b1, 3'b111, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
